// File: rtl/tlul_pkg.sv
// TL-UL channel types shared by the register-bus arbiter and its neighbours.
// Only the fields the register path needs; integrity bits travel in the user fields.
package tlul_pkg;

    localparam int TL_AW   = 32;
    localparam int TL_DW   = 32;
    localparam int TL_AIW  = 8;
    localparam int TL_DIW  = 1;
    localparam int TL_DBW  = TL_DW / 8;
    localparam int TL_SZW  = 2;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [3:0] instr_type;
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        tl_a_user_t        a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        tl_d_user_t        d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

    localparam tl_h2d_t TL_H2D_DEFAULT = '{a_opcode: PutFullData, default: '0};
    localparam tl_d2h_t TL_D2H_DEFAULT = '{d_opcode: AccessAck, default: '0};

endpackage

// File: rtl/tlul_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after i_ptr,
// wrapping past N-1 back to 0.
module tlul_rr_pick #(
    parameter  int N    = 2,
    localparam int PtrW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    i_req,
    input  logic [PtrW-1:0] i_ptr,
    output logic            o_valid,
    output logic [PtrW-1:0] o_idx
);

    int w_cand;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = 0;
        // Walk offsets from farthest to nearest so the nearest requester wins last.
        for (int i = N - 1; i >= 0; i--) begin
            w_cand = (int'(i_ptr) + i) % N;
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = PtrW'(w_cand);
            end
        end
    end

endmodule

// File: rtl/tlul_reg_host_arb.sv
// Round-robin arbiter sharing one TL-UL register device port between NumHosts hosts.
// One transaction in flight; grant is registered, so arbitration costs one bubble cycle.
module tlul_reg_host_arb
    import tlul_pkg::*;
#(
    parameter  int NumHosts = 2,
    localparam int PtrW     = (NumHosts > 1) ? $clog2(NumHosts) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  tl_h2d_t         tl_h_i [NumHosts],
    output tl_d2h_t         tl_h_o [NumHosts],
    output tl_h2d_t         tl_d_o,
    input  tl_d2h_t         tl_d_i,
    output logic            busy_o,
    output logic [PtrW-1:0] owner_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RSP
    } state_e;

    state_e              r_state;
    logic [PtrW-1:0]     r_owner;
    logic [PtrW-1:0]     r_rr_ptr;
    logic                r_busy;

    logic [NumHosts-1:0] w_req;
    logic                w_pick_valid;
    logic [PtrW-1:0]     w_pick_idx;
    logic                w_a_ack;
    logic                w_d_ack;

    always_comb begin
        w_req = '0;
        for (int i = 0; i < NumHosts; i++) begin
            w_req[i] = tl_h_i[i].a_valid;
        end
    end

    tlul_rr_pick #(
        .N (NumHosts)
    ) u_pick (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    assign w_a_ack = tl_h_i[r_owner].a_valid & tl_d_i.a_ready;
    assign w_d_ack = tl_d_i.d_valid & tl_h_i[r_owner].d_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_owner <= w_pick_idx;
                        r_busy  <= 1'b1;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_a_ack) begin
                        r_state <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (w_d_ack) begin
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= (r_owner == PtrW'(NumHosts - 1)) ? '0 : r_owner + PtrW'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Channel steering depends only on registered state, never on a_valid directly.
    always_comb begin
        tl_d_o = TL_H2D_DEFAULT;
        for (int i = 0; i < NumHosts; i++) begin
            tl_h_o[i] = TL_D2H_DEFAULT;
        end
        case (r_state)
            ST_REQ: begin
                tl_d_o                 = tl_h_i[r_owner];
                tl_d_o.d_ready         = 1'b0;
                tl_h_o[r_owner].a_ready = tl_d_i.a_ready;
            end
            ST_RSP: begin
                tl_d_o.d_ready          = tl_h_i[r_owner].d_ready;
                tl_h_o[r_owner]         = tl_d_i;
                tl_h_o[r_owner].a_ready = 1'b0;
            end
            default: begin
            end
        endcase
    end

    assign busy_o  = r_busy;
    assign owner_o = r_owner;

    // Protocol violations are flagged here; the FSM itself does not try to recover.
    a_valid_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_state == ST_REQ) |-> tl_h_i[r_owner].a_valid);

    d_valid_in_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_state != ST_RSP) |-> !tl_d_i.d_valid);

endmodule
